// File: rtl/axi_pkg.sv
// Shared AXI types for the memory responder: burst and response encodings,
// channel FSM states, and the worst-of response merge.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    // Worst response wins: DECERR > SLVERR > EXOKAY > OKAY.
    function automatic resp_t resp_merge(input resp_t a, input resp_t b);
        if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
        if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
        if (a == RESP_EXOKAY || b == RESP_EXOKAY) return RESP_EXOKAY;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst address stepper and burst legality check.
// Ports: addr/len/size/burst describe the current beat; next_addr is the
// byte address of the following beat; illegal flags an unsupported size,
// the reserved burst type or a WRAP length other than 2/4/8/16 beats.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              illegal
);

    localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_len_ok;

    always_comb begin
        incr        = ADDR_W'(1) << size;
        wrap_mask   = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

        illegal = (32'(size) > BYTE_SH)
               || (burst == 2'b11)
               || (burst == BURST_WRAP && !wrap_len_ok);

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + incr;
            // Keep the upper bits, let the low bits roll over inside the wrap window.
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a word-addressed memory array. Read (AR/R) and
// write (AW/W/B) channels run on independent FSMs and may overlap freely.
// Ports: clk, reset (async active-low), full AXI4 AR/R/AW/W/B channels.
// Lock/cache/prot/qos/region and wid are accepted but ignored.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    // read address
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arport,
    input  logic [3:0]          axi_arqos,
    input  logic [3:0]          axi_arregion,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    // read data
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    // write address
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awport,
    input  logic [3:0]          axi_awqos,
    input  logic [3:0]          axi_awregion,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    // write data
    input  logic [ID_W-1:0]     axi_wid,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    // write response
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned BYTE_SH = $clog2(STRB_W);
    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ---------------- read channel state ----------------
    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic [ADDR_W-1:0] r_gen_addr_c;
    logic [7:0]        r_gen_len_c;
    logic [2:0]        r_gen_size_c;
    logic [1:0]        r_gen_burst_c;
    logic [ADDR_W-1:0] r_next_c;
    logic              r_illegal_c;
    logic [ADDR_W-1:0] r_load_addr_c;
    logic [ADDR_W-1:0] r_word_c;
    resp_t             r_resp_c;
    logic [DATA_W-1:0] r_data_c;

    // In idle the stepper sees the incoming AR so the first beat's legality is
    // known at the handshake; afterwards it steps the latched burst.
    always_comb begin
        if (r_state == R_IDLE) begin
            r_gen_addr_c  = axi_araddr;
            r_gen_len_c   = axi_arlen;
            r_gen_size_c  = axi_arsize;
            r_gen_burst_c = axi_arburst;
        end else begin
            r_gen_addr_c  = r_addr;
            r_gen_len_c   = r_len;
            r_gen_size_c  = r_size;
            r_gen_burst_c = r_burst;
        end
    end

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr (
        .addr      (r_gen_addr_c),
        .len       (r_gen_len_c),
        .size      (r_gen_size_c),
        .burst     (r_gen_burst_c),
        .next_addr (r_next_c),
        .illegal   (r_illegal_c)
    );

    // Address of the beat being loaded into the R output registers.
    always_comb begin
        r_load_addr_c = (r_state == R_IDLE) ? axi_araddr : r_next_c;
        r_word_c      = (r_load_addr_c - BASE_ADDR) >> BYTE_SH;
        if (r_word_c >= ADDR_W'(MEM_WORDS))
            r_resp_c = RESP_DECERR;
        else if (r_illegal_c)
            r_resp_c = RESP_SLVERR;
        else
            r_resp_c = RESP_OKAY;
        r_data_c = (r_resp_c == RESP_OKAY) ? mem[r_word_c[IDX_W-1:0]] : '0;
    end

    // Read FSM: registered R outputs, next beat loaded on each handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            axi_arready <= 1'b1;
            axi_rvalid  <= 1'b0;
            axi_rid     <= '0;
            axi_rdata   <= '0;
            axi_rresp   <= '0;
            axi_rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_arvalid && axi_arready) begin
                        r_addr      <= axi_araddr;
                        r_len       <= axi_arlen;
                        r_size      <= axi_arsize;
                        r_burst     <= axi_arburst;
                        r_cnt       <= '0;
                        axi_arready <= 1'b0;
                        axi_rvalid  <= 1'b1;
                        axi_rid     <= axi_arid;
                        axi_rdata   <= r_data_c;
                        axi_rresp   <= r_resp_c;
                        axi_rlast   <= (axi_arlen == 8'd0);
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_rready) begin
                        if (axi_rlast) begin
                            axi_rvalid  <= 1'b0;
                            axi_rlast   <= 1'b0;
                            axi_arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_addr    <= r_next_c;
                            r_cnt     <= r_cnt + 8'd1;
                            axi_rdata <= r_data_c;
                            axi_rresp <= r_resp_c;
                            axi_rlast <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel state ----------------
    wr_state_t         w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    resp_t             w_acc;

    logic [ADDR_W-1:0] w_next_c;
    logic              w_illegal_c;
    logic [ADDR_W-1:0] w_word_c;
    resp_t             w_resp_c;
    logic              w_last_c;
    logic              w_mism_c;
    resp_t             w_beat_c;
    logic              mem_we_c;

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next_c),
        .illegal   (w_illegal_c)
    );

    // Per-beat write response; a wlast that disagrees with the count is SLVERR.
    always_comb begin
        w_word_c = (w_addr - BASE_ADDR) >> BYTE_SH;
        if (w_word_c >= ADDR_W'(MEM_WORDS))
            w_resp_c = RESP_DECERR;
        else if (w_illegal_c)
            w_resp_c = RESP_SLVERR;
        else
            w_resp_c = RESP_OKAY;
        w_last_c = (w_cnt == w_len);
        w_mism_c = (axi_wlast != w_last_c);
        w_beat_c = resp_merge(w_resp_c, w_mism_c ? RESP_SLVERR : RESP_OKAY);
        mem_we_c = (w_state == W_DATA) && axi_wvalid && axi_wready && (w_beat_c == RESP_OKAY);
    end

    // Byte-lane memory write; memory has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_wstrb[i])
                    mem[w_word_c[IDX_W-1:0]][i*8 +: 8] <= axi_wdata[i*8 +: 8];
            end
        end
    end

    // Write FSM: burst length comes from awlen, response is the worst beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_acc       <= RESP_OKAY;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bid     <= '0;
            axi_bresp   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_awvalid && axi_awready) begin
                        w_addr      <= axi_awaddr;
                        w_len       <= axi_awlen;
                        w_size      <= axi_awsize;
                        w_burst     <= axi_awburst;
                        w_cnt       <= '0;
                        w_acc       <= RESP_OKAY;
                        axi_bid     <= axi_awid;
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid && axi_wready) begin
                        if (w_last_c) begin
                            axi_wready <= 1'b0;
                            axi_bvalid <= 1'b1;
                            axi_bresp  <= resp_merge(w_acc, w_beat_c);
                            w_state    <= W_RESP;
                        end else begin
                            w_acc  <= resp_merge(w_acc, w_beat_c);
                            w_addr <= w_next_c;
                            w_cnt  <= w_cnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Sideband fields that this responder does not act on.
    logic unused_c;
    assign unused_c = ^{axi_arlock, axi_arcache, axi_arport, axi_arqos, axi_arregion,
                        axi_awlock, axi_awcache, axi_awport, axi_awqos, axi_awregion,
                        axi_wid};

endmodule
